// File: rtl/ext_in_cntrl.sv
// Input-port controller for the IN instruction: buffers producer bytes in a FIFO and stalls the PC on an empty read.
// Optional build macro EXT_IN_BYPASS_EN lets an IN on an empty FIFO take the producer byte directly.
module ext_in_cntrl #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   ext_data,
  input  logic                         ext_valid,
  output logic                         ext_ready,
  input  logic [3:0]                   op,
  input  logic                         in_en,
  output logic [7:0]                   in_data,
  output logic                         pc_en,
  output logic                         in_avail,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [3:0] OP_IN = 4'h7;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          rd_req, empty, byp, push, pop;

  // Handshake: a byte transfers on any posedge where ext_valid && ext_ready; the
  // producer holds ext_data/ext_valid stable until that transfer has happened.
  assign rd_req = in_en && (op == OP_IN);
  assign empty  = (count == '0);

`ifdef EXT_IN_BYPASS_EN
  assign byp = !rst && rd_req && empty && ext_valid;
`else
  assign byp = 1'b0;
`endif

  assign ext_ready  = !rst && ((count < FULL) || byp);
  // A bypassed byte is consumed by the IN directly and never enters the array.
  assign push       = ext_valid && ext_ready && !byp;
  assign pop        = rd_req && !empty;
  assign in_avail   = !empty;
  assign fifo_count = count;
  assign pc_en      = !(rd_req && empty) || byp;
  assign in_data    = !empty ? mem[rd_ptr] : (byp ? ext_data : 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ext_data;
  end

endmodule

// File: tb/tb_ext_in_cntrl.sv
// Directed bench for ext_in_cntrl: fill/full, ordered wrap drain, empty stall, push/pop, and mid-stream reset.
module tb_ext_in_cntrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ext_data;
  logic       ext_valid;
  logic       ext_ready;
  logic [3:0] op;
  logic       in_en;
  logic [7:0] in_data;
  logic       pc_en;
  logic       in_avail;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] b;

  always #5 clk = ~clk;

  ext_in_cntrl #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ext_data(ext_data), .ext_valid(ext_valid),
    .ext_ready(ext_ready), .op(op), .in_en(in_en), .in_data(in_data),
    .pc_en(pc_en), .in_avail(in_avail), .fifo_count(fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then let outputs settle away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ext_data = 8'h00; ext_valid = 1'b0; op = 4'h0; in_en = 1'b0;
    #2;
    chk("rst_ready", ext_ready, 0);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_avail", in_avail, 0);
    chk("rst_data", in_data, 8'h00);
    chk("rst_count", fifo_count, 0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("idle_ready", ext_ready, 1);
    chk("idle_pc_en", pc_en, 1);
    chk("idle_count", fifo_count, 0);

    // Fill to full
    ext_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ext_data = 8'hA1 + 8'(i);
      cyc();
    end
    ext_data = 8'hA5;
    #1;
    chk("full_count", fifo_count, 4);
    chk("full_ready", ext_ready, 0);
    chk("full_head", in_data, 8'hA1);
    cyc();
    chk("full_hold_count", fifo_count, 4);
    op = 4'h7; in_en = 1'b1;
    #1;
    chk("full_pop_data", in_data, 8'hA1);
    chk("full_pop_pc_en", pc_en, 1);
    cyc();
    chk("after_pop_count", fifo_count, 3);
    chk("after_pop_ready", ext_ready, 1);
    chk("after_pop_head", in_data, 8'hA2);
    in_en = 1'b0;
    cyc();
    ext_valid = 1'b0;
    #1;
    chk("refill_count", fifo_count, 4);
    exp_q = {8'hA2, 8'hA3, 8'hA4, 8'hA5};
    in_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      b = exp_q.pop_front();
      chk("drain_a", in_data, b);
      cyc();
    end
    in_en = 1'b0;
    #1;
    chk("drain_a_count", fifo_count, 0);
    chk("drain_a_avail", in_avail, 0);

    // Ordered interleaved drain; pointers wrap
    for (int i = 0; i < 6; i++) exp_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 6; i++) begin
      ext_valid = 1'b1; ext_data = 8'h10 + 8'(i); in_en = 1'b0;
      cyc();
      ext_valid = 1'b0; in_en = 1'b1;
      #1;
      b = exp_q.pop_front();
      chk("wrap_data", in_data, b);
      chk("wrap_pc_en", pc_en, 1);
      cyc();
    end
    in_en = 1'b0;
    #1;
    chk("wrap_count", fifo_count, 0);

    // IN on empty FIFO stalls
    op = 4'h7; in_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_pc_en", pc_en, 0);
      chk("stall_data", in_data, 8'h00);
      cyc();
    end
    ext_valid = 1'b1; ext_data = 8'h5C;
    #1;
`ifdef EXT_IN_BYPASS_EN
    chk("byp_pc_en", pc_en, 1);
    chk("byp_data", in_data, 8'h5C);
    chk("byp_ready", ext_ready, 1);
    cyc();
    ext_valid = 1'b0; in_en = 1'b0;
    #1;
    chk("byp_count", fifo_count, 0);
`else
    chk("push_cycle_pc_en", pc_en, 0);
    chk("push_cycle_data", in_data, 8'h00);
    chk("push_cycle_ready", ext_ready, 1);
    cyc();
    ext_valid = 1'b0;
    #1;
    chk("deliver_pc_en", pc_en, 1);
    chk("deliver_data", in_data, 8'h5C);
    cyc();
    in_en = 1'b0;
    #1;
    chk("deliver_count", fifo_count, 0);
`endif

    // Simultaneous push and pop at count 2
    in_en = 1'b0; ext_valid = 1'b1;
    ext_data = 8'h20; cyc();
    ext_data = 8'h21; cyc();
    ext_data = 8'h22; op = 4'h7; in_en = 1'b1;
    #1;
    chk("pp_before_count", fifo_count, 2);
    chk("pp_before_head", in_data, 8'h20);
    cyc();
    ext_valid = 1'b0; op = 4'h6; in_en = 1'b1;
    #1;
    chk("pp_count", fifo_count, 2);
    chk("pp_head", in_data, 8'h21);
    chk("op6_pc_en", pc_en, 1);
    cyc();
    chk("op6_count", fifo_count, 2);
    op = 4'h7; in_en = 1'b0;
    cyc();
    chk("noen_count", fifo_count, 2);
    chk("noen_pc_en", pc_en, 1);

    // Reset mid-stream at count 3
    ext_valid = 1'b1; ext_data = 8'h23;
    cyc();
    ext_valid = 1'b0;
    #1;
    chk("pre_rst_count", fifo_count, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_ready", ext_ready, 0);
    chk("mid_rst_data", in_data, 8'h00);
    cyc();
    #2;
    rst = 1'b0;
    op = 4'h7; in_en = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("post_rst_pc_en", pc_en, 0);
      chk("post_rst_data", in_data, 8'h00);
      chk("post_rst_avail", in_avail, 0);
      cyc();
    end
    in_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
